// File: rtl/apb_uart.sv
// apb_uart: APB3 slave UART with a CMSDK-style register map.
// 8N1 transmitter and receiver, one-byte buffer each way, integer baud divider.
// Optional macro APB_UART_IRQ_EN adds the registered TXINT/RXINT/UARTINT outputs.
module apb_uart #(
    parameter int unsigned BAUD_W = 20
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic [11:2] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        RXD,
    output logic        TXD,
    output logic        TXEN
`ifdef APB_UART_IRQ_EN
    ,
    output logic        TXINT,
    output logic        RXINT,
    output logic        UARTINT
`endif
);

    localparam logic [9:0] A_DATA  = 10'h000;
    localparam logic [9:0] A_STATE = 10'h001;
    localparam logic [9:0] A_CTRL  = 10'h002;
    localparam logic [9:0] A_INT   = 10'h003;
    localparam logic [9:0] A_BAUD  = 10'h004;
    localparam logic [BAUD_W-1:0] BAUD_MIN = BAUD_W'(16);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // programmer-visible registers
    logic [3:0]        r_ctrl;
    logic [BAUD_W-1:0] r_baud;
    logic [1:0]        r_int;
    logic              r_tx_full, r_tx_ovr, r_rx_full, r_rx_ovr;
    logic [7:0]        r_tx_buf, r_rx_buf;

    // transmit shifter
    tx_state_t         r_tx_state, w_tx_state_n;
    logic [BAUD_W-1:0] r_tx_cnt, r_tx_period;
    logic [7:0]        r_tx_sr;
    logic [2:0]        r_tx_idx;
    logic              r_txd;

    // receive shifter
    rx_state_t         r_rx_state, w_rx_state_n;
    logic [BAUD_W-1:0] r_rx_cnt, r_rx_period;
    logic [7:0]        r_rx_sr;
    logic [2:0]        r_rx_idx;
    logic              r_rx_s1, r_rx_s2, r_rx_prev;

    logic w_wr, w_rd;
    logic w_wr_data, w_wr_state, w_wr_ctrl, w_wr_int, w_wr_baud, w_rd_data;
    logic w_halt, w_tx_end, w_tx_move, w_tx_accept, w_tx_drop;
    logic w_rx_run, w_rx_tick, w_rx_half, w_rx_done, w_rx_load;
    logic w_unused_pwdata;

    assign w_wr       = PSEL & PENABLE & PWRITE;
    assign w_rd       = PSEL & PENABLE & ~PWRITE;
    assign w_wr_data  = w_wr & (PADDR == A_DATA);
    assign w_wr_state = w_wr & (PADDR == A_STATE);
    assign w_wr_ctrl  = w_wr & (PADDR == A_CTRL);
    assign w_wr_int   = w_wr & (PADDR == A_INT);
    assign w_wr_baud  = w_wr & (PADDR == A_BAUD);
    assign w_rd_data  = w_rd & (PADDR == A_DATA);
    assign w_unused_pwdata = ^PWDATA[31:BAUD_W];

    assign w_halt      = (r_baud < BAUD_MIN);
    assign w_tx_end    = ~w_halt & (r_tx_cnt == r_tx_period - BAUD_W'(1));
    assign w_tx_move   = r_tx_full & r_ctrl[0] & ~w_halt &
                         ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_end));
    assign w_tx_accept = w_wr_data & ~r_tx_full;
    assign w_tx_drop   = w_wr_data & r_tx_full;

    assign w_rx_run  = r_ctrl[1];
    assign w_rx_tick = ~w_halt & (r_rx_cnt == r_rx_period - BAUD_W'(1));
    assign w_rx_half = ~w_halt & (r_rx_cnt == (r_rx_period >> 1) - BAUD_W'(1));
    assign w_rx_done = (r_rx_state == RX_STOP) & w_rx_run & w_rx_tick & r_rx_s2;
    assign w_rx_load = w_rx_done & ~r_rx_full;

    assign PREADY = 1'b1;
    assign TXD    = r_txd;
    assign TXEN   = r_ctrl[0];

    // register file updates; a set and a clear in the same cycle leaves the flag set
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ctrl    <= '0;
            r_baud    <= '0;
            r_int     <= '0;
            r_tx_full <= 1'b0;
            r_tx_ovr  <= 1'b0;
            r_rx_full <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_tx_buf  <= '0;
            r_rx_buf  <= '0;
        end else begin
            if (w_wr_ctrl)   r_ctrl   <= PWDATA[3:0];
            if (w_wr_baud)   r_baud   <= PWDATA[BAUD_W-1:0];
            if (w_tx_accept) r_tx_buf <= PWDATA[7:0];
            if (w_rx_load)   r_rx_buf <= r_rx_sr;
            r_tx_full <= w_tx_accept | (r_tx_full & ~w_tx_move);
            r_tx_ovr  <= w_tx_drop | (r_tx_ovr & ~(w_wr_state & PWDATA[2]));
            r_rx_full <= w_rx_load | (r_rx_full & ~w_rd_data);
            r_rx_ovr  <= (w_rx_done & r_rx_full) | (r_rx_ovr & ~(w_wr_state & PWDATA[3]));
            r_int[0]  <= (w_tx_move & r_ctrl[2]) | (r_int[0] & ~(w_wr_int & PWDATA[0]));
            r_int[1]  <= (w_rx_load & r_ctrl[3]) | (r_int[1] & ~(w_wr_int & PWDATA[1]));
        end
    end

    // combinational read mux
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                A_DATA:  PRDATA = {24'h0, r_rx_buf};
                A_STATE: PRDATA = {28'h0, r_rx_ovr, r_tx_ovr, r_rx_full, r_tx_full};
                A_CTRL:  PRDATA = {28'h0, r_ctrl};
                A_INT:   PRDATA = {30'h0, r_int};
                A_BAUD:  PRDATA = 32'(r_baud);
                default: PRDATA = '0;
            endcase
        end
    end

    // TX state register
    always_ff @(posedge PCLK) begin
        if (PRESET) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_state_n;
    end

    // TX next state; a queued byte restarts straight from the stop bit
    always_comb begin
        w_tx_state_n = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_move) w_tx_state_n = TX_START;
            TX_START: if (w_tx_end) w_tx_state_n = TX_DATA;
            TX_DATA:  if (w_tx_end && r_tx_idx == 3'd7) w_tx_state_n = TX_STOP;
            TX_STOP:  if (w_tx_end) w_tx_state_n = w_tx_move ? TX_START : TX_IDLE;
            default:  w_tx_state_n = TX_IDLE;
        endcase
    end

    // TX bit timing and serial output; the divider is re-latched at every bit boundary
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_txd       <= 1'b1;
            r_tx_cnt    <= '0;
            r_tx_period <= '0;
            r_tx_sr     <= '0;
            r_tx_idx    <= '0;
        end else if (w_tx_move) begin
            r_txd       <= 1'b0;
            r_tx_sr     <= r_tx_buf;
            r_tx_cnt    <= '0;
            r_tx_period <= r_baud;
            r_tx_idx    <= '0;
        end else if (r_tx_state != TX_IDLE && w_tx_end) begin
            r_tx_cnt    <= '0;
            r_tx_period <= r_baud;
            case (r_tx_state)
                TX_START: r_txd <= r_tx_sr[0];
                TX_DATA: begin
                    r_tx_idx <= r_tx_idx + 3'd1;
                    r_tx_sr  <= r_tx_sr >> 1;
                    r_txd    <= (r_tx_idx == 3'd7) ? 1'b1 : r_tx_sr[1];
                end
                default:  r_txd <= 1'b1;
            endcase
        end else if (r_tx_state != TX_IDLE && !w_halt) begin
            r_tx_cnt <= r_tx_cnt + BAUD_W'(1);
        end
    end

    // RX state register
    always_ff @(posedge PCLK) begin
        if (PRESET) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_state_n;
    end

    // RX next state; a start bit that is high at mid-bit is treated as a glitch
    always_comb begin
        w_rx_state_n = r_rx_state;
        if (!w_rx_run) begin
            w_rx_state_n = RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE:  if (!w_halt && r_rx_prev && !r_rx_s2) w_rx_state_n = RX_START;
                RX_START: if (w_rx_half) w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (w_rx_tick && r_rx_idx == 3'd7) w_rx_state_n = RX_STOP;
                RX_STOP:  if (w_rx_tick) w_rx_state_n = RX_IDLE;
                default:  w_rx_state_n = RX_IDLE;
            endcase
        end
    end

    // RX synchroniser, bit timing and shift-in (LSB first)
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_cnt    <= '0;
            r_rx_period <= '0;
            r_rx_sr     <= '0;
            r_rx_idx    <= '0;
        end else begin
            r_rx_s1   <= RXD;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (r_rx_state == RX_IDLE) begin
                r_rx_cnt    <= '0;
                r_rx_period <= r_baud;
                r_rx_idx    <= '0;
            end else if ((r_rx_state == RX_START && w_rx_half) ||
                         (r_rx_state != RX_START && w_rx_tick)) begin
                r_rx_cnt    <= '0;
                r_rx_period <= r_baud;
                if (r_rx_state == RX_DATA) begin
                    r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
                    r_rx_idx <= r_rx_idx + 3'd1;
                end
            end else if (!w_halt) begin
                r_rx_cnt <= r_rx_cnt + BAUD_W'(1);
            end
        end
    end

`ifdef APB_UART_IRQ_EN
    logic r_txint, r_rxint, r_uartint;

    // registered interrupt outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_txint   <= 1'b0;
            r_rxint   <= 1'b0;
            r_uartint <= 1'b0;
        end else begin
            r_txint   <= r_int[0];
            r_rxint   <= r_int[1];
            r_uartint <= r_int[0] | r_int[1] | (r_tx_ovr & r_ctrl[2]) | (r_rx_ovr & r_ctrl[3]);
        end
    end

    assign TXINT   = r_txint;
    assign RXINT   = r_rxint;
    assign UARTINT = r_uartint;
`endif

endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: directed self-checking bench for apb_uart (default build, no IRQ ports).
module tb_apb_uart;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic [11:2] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        RXD;
    logic        TXD;
    logic        TXEN;
    logic        r_loop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 PCLK = ~PCLK;

    assign RXD = r_loop ? TXD : 1'b1;

    apb_uart dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .RXD     (RXD),
        .TXD     (TXD),
        .TXEN    (TXEN)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] off, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = off[11:2]; PWDATA = d; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] off, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = off[11:2]; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (TXD === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
    endtask

    // Called on the first negedge of a start bit; returns on the first negedge after the frame.
    task automatic check_frame(input string tag, input logic [7:0] b, input int baud);
        logic [9:0] f;
        int errs;
        f = {1'b1, b, 1'b0};
        errs = 0;
        for (int c = 0; c < 10 * baud; c++) begin
            if (TXD !== f[c / baud]) errs++;
            @(negedge PCLK);
        end
        check(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit ok;
        int errs;

        PRESET = 1'b1; PSEL = 1'b0; PADDR = '0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; r_loop = 1'b0;

        // reset values
        repeat (5) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_txd", 32'(TXD), 32'd1);
        check("rst_txen", 32'(TXEN), 32'd0);
        check("rst_pready", 32'(PREADY), 32'd1);
        PRESET = 1'b0;
        check("rst_prdata_idle", PRDATA, 32'd0);
        for (int a = 0; a < 5; a++) begin
            apb_read(12'(a * 4), d);
            check($sformatf("rst_read_%0h", a * 4), d, 32'd0);
        end

        // single frame 0x55 at BAUDDIV=16 with TX interrupt
        apb_write(12'h010, 32'd16);
        apb_write(12'h008, 32'h5);
        check("txen_on", 32'(TXEN), 32'd1);
        apb_write(12'h000, 32'h55);
        wait_low(20, ok);
        check("tx55_start_seen", 32'(ok), 32'd1);
        check_frame("tx55_frame", 8'h55, 16);
        check("tx55_idle_after", 32'(TXD), 32'd1);
        apb_read(12'h00C, d);
        check("tx55_intstatus", d, 32'h1);
        apb_read(12'h004, d);
        check("tx55_state", d, 32'h0);
        apb_write(12'h00C, 32'h1);
        apb_read(12'h00C, d);
        check("intclear", d, 32'h0);

        // back-to-back frames plus a dropped third byte
        apb_write(12'h008, 32'h1);
        fork
            begin
                apb_write(12'h000, 32'hA5);
                apb_write(12'h000, 32'h3C);
                apb_write(12'h000, 32'h77);
            end
            begin
                wait_low(20, ok);
                check("b2b_start_seen", 32'(ok), 32'd1);
                check_frame("b2b_frame_a5", 8'hA5, 16);
                check("b2b_no_gap", 32'(TXD), 32'd0);
                check_frame("b2b_frame_3c", 8'h3C, 16);
                check("b2b_idle_after", 32'(TXD), 32'd1);
            end
        join
        apb_read(12'h004, d);
        check("txovr_state", d, 32'h4);
        apb_write(12'h004, 32'h4);
        apb_read(12'h004, d);
        check("txovr_cleared", d, 32'h0);

        // loopback receive of 0xC3
        r_loop = 1'b1;
        apb_write(12'h008, 32'hF);
        apb_write(12'h000, 32'hC3);
        d = '0;
        for (int i = 0; i < 150; i++) begin
            apb_read(12'h004, d);
            if (d[1]) break;
        end
        check("rx_state_full", d, 32'h2);
        apb_read(12'h00C, d);
        check("rx_intstatus", d, 32'h3);
        apb_read(12'h000, d);
        check("rx_data", d, 32'hC3);
        apb_read(12'h004, d);
        check("rx_full_cleared", d, 32'h0);
        repeat (60) @(negedge PCLK);
        apb_write(12'h008, 32'h1);
        r_loop = 1'b0;
        apb_write(12'h00C, 32'h3);

        // divider below 16 halts; raising it releases the held byte
        apb_write(12'h010, 32'd8);
        apb_write(12'h000, 32'h11);
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (TXD !== 1'b1) errs++;
        end
        check("halt_txd_high", 32'(errs), 32'd0);
        apb_read(12'h004, d);
        check("halt_txfull", d, 32'h1);
        apb_write(12'h010, 32'd32);
        wait_low(20, ok);
        check("b32_start_seen", 32'(ok), 32'd1);
        check_frame("b32_frame", 8'h11, 32);
        check("b32_idle_after", 32'(TXD), 32'd1);

        // reset in the middle of a frame
        apb_write(12'h010, 32'd16);
        apb_write(12'h000, 32'h00);
        wait_low(20, ok);
        check("mid_start_seen", 32'(ok), 32'd1);
        repeat (40) @(negedge PCLK);
        check("mid_txd_low", 32'(TXD), 32'd0);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("mid_rst_txd", 32'(TXD), 32'd1);
        @(negedge PCLK);
        PRESET = 1'b0;
        check("mid_rst_txen", 32'(TXEN), 32'd0);
        for (int a = 0; a < 5; a++) begin
            apb_read(12'(a * 4), d);
            check($sformatf("mid_rst_read_%0h", a * 4), d, 32'd0);
        end
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (TXD !== 1'b1) errs++;
        end
        check("mid_rst_txd_stays", 32'(errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
